// File: rtl/mul_hilo_ctrl_if.sv
// Handshake and data bundle between control, multiplier and the HI/LO sequencer.
// The master drives requests and multiplier results; the slave is the sequencer.
interface mul_hilo_ctrl_if #(
    parameter int W = 32
);
    logic         start;
    logic         abort;
    logic [W-1:0] ra_in;
    logic [W-1:0] rb_in;
    logic [W-1:0] mul_ra;
    logic [W-1:0] mul_rb;
    logic [W-1:0] mul_hi;
    logic [W-1:0] mul_lo;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] bus_in;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;

    modport master (
        output start, abort, ra_in, rb_in,
        output mul_hi, mul_lo,
        output hi_we, lo_we, bus_in,
        input  mul_ra, mul_rb,
        input  hi_out, lo_out,
        input  busy, done
    );

    modport slave (
        input  start, abort, ra_in, rb_in,
        input  mul_hi, mul_lo,
        input  hi_we, lo_we, bus_in,
        output mul_ra, mul_rb,
        output hi_out, lo_out,
        output busy, done
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencer around a combinational multiplier.
// Holds operands, waits for settle, commits the product; serves mthi/mtlo.
module mul_hilo_ctrl #(
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input logic              clk,
    input logic              clr_n,
    mul_hilo_ctrl_if.slave   io
);
    localparam int CW = 4;
    localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COMMIT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0]  ra_q, ra_nx;
    logic [W-1:0]  rb_q, rb_nx;
    logic [W-1:0]  hi_q, hi_nx;
    logic [W-1:0]  lo_q, lo_nx;
    logic          busy_q, busy_nx;
    logic          done_q, done_nx;

    // State and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ra_q   <= ra_nx;
            rb_q   <= rb_nx;
            hi_q   <= hi_nx;
            lo_q   <= lo_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    // Next-state: abort wins over commit; mt* writes only land while idle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ra_nx    = ra_q;
        rb_nx    = rb_q;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (io.hi_we) hi_nx = io.bus_in;
                if (io.lo_we) lo_nx = io.bus_in;
                if (io.start && !io.abort) begin
                    ra_nx    = io.ra_in;
                    rb_nx    = io.rb_in;
                    cnt_nx   = LAT_M1;
                    state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (io.abort) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    state_nx = S_COMMIT;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_COMMIT: begin
                state_nx = S_IDLE;
                if (!io.abort) begin
                    hi_nx   = io.mul_hi;
                    lo_nx   = io.mul_lo;
                    done_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    assign io.mul_ra = ra_q;
    assign io.mul_rb = rb_q;
    assign io.hi_out = hi_q;
    assign io.lo_out = lo_q;
    assign io.busy   = busy_q;
    assign io.done   = done_q;
endmodule
